// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two writeback requesters,
// with a registered write stage and a pending-write scoreboard for the issue logic.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [4:0]            req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [4:0]            req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,

  input  logic                  claim_valid,
  input  logic [4:0]            claim_addr,
  output logic [31:0]           busy,

  output logic                  rf_we,
  output logic [4:0]            rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  logic        ptr;
  logic        zero0;
  logic        zero1;
  logic        live0;
  logic        live1;
  logic        grant0;
  logic        grant1;
  logic [31:0] busy_next;

  // Writes to x0 are swallowed without touching the grant logic.
  always_comb begin
    zero0  = req0_valid && (req0_addr == 5'd0);
    zero1  = req1_valid && (req1_addr == 5'd0);
    live0  = req0_valid && (req0_addr != 5'd0);
    live1  = req1_valid && (req1_addr != 5'd0);
    grant0 = live0 && (!live1 || !ptr);
    grant1 = live1 && (!live0 ||  ptr);
    req0_ready = zero0 || grant0;
    req1_ready = zero1 || grant1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (grant0) begin
      ptr <= 1'b1;
    end else if (grant1) begin
      ptr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_addr  <= 5'd0;
      rf_wdata <= '0;
    end else if (grant0) begin
      rf_we    <= 1'b1;
      rf_addr  <= req0_addr;
      rf_wdata <= req0_data;
    end else if (grant1) begin
      rf_we    <= 1'b1;
      rf_addr  <= req1_addr;
      rf_wdata <= req1_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Claim is applied after the clear so a same-edge claim keeps the bit set.
  always_comb begin
    busy_next = busy;
    if (rf_we) begin
      busy_next[rf_addr] = 1'b0;
    end
    if (claim_valid && (claim_addr != 5'd0)) begin
      busy_next[claim_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the arbiter.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        claim_valid;
  logic [4:0]  claim_addr;
  logic [31:0] busy;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  // Model state: the write in flight, who is favoured next, and the set of pending registers.
  bit        m_we;
  bit [4:0]  m_addr;
  bit [31:0] m_wdata;
  int        m_next;
  bit        m_pending[32];

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .claim_valid(claim_valid),
    .claim_addr (claim_addr),
    .busy       (busy),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pending_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_pending[i];
    return v;
  endfunction

  task automatic model_reset();
    m_we = 0; m_addr = 0; m_wdata = 0; m_next = 0;
    for (int i = 0; i < 32; i++) m_pending[i] = 0;
  endtask

  // Called just after a falling edge; returns the model and DUT readies for this cycle.
  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      input logic cv, input logic [4:0] ca,
                      output logic mr0, output logic mr1,
                      output logic dr0, output logic dr1);
    int cand[$];
    int win;
    check("rf_we",    rf_we,    m_we);
    check("rf_addr",  rf_addr,  m_addr);
    check("rf_wdata", rf_wdata, m_wdata);
    check("busy",     busy,     pending_vec());
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    claim_valid = cv; claim_addr = ca;
    #1;
    if (v0 && a0 != 0) cand.push_back(0);
    if (v1 && a1 != 0) cand.push_back(1);
    win = -1;
    if (cand.size() == 1) win = cand[0];
    else if (cand.size() == 2) win = m_next;
    mr0 = (v0 && a0 == 0) || (win == 0);
    mr1 = (v1 && a1 == 0) || (win == 1);
    dr0 = req0_ready;
    dr1 = req1_ready;
    check("req0_ready", dr0, mr0);
    check("req1_ready", dr1, mr1);
    @(posedge clk);
    if (m_we) m_pending[m_addr] = 0;
    if (cv && ca != 0) m_pending[ca] = 1;
    if (win == 0) begin
      m_we = 1; m_addr = a0; m_wdata = d0; m_next = 1;
    end else if (win == 1) begin
      m_we = 1; m_addr = a1; m_wdata = d1; m_next = 0;
    end else begin
      m_we = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic cv, input logic [4:0] ca);
    logic a, b, c, d;
    step(0, 0, 0, 0, 0, 0, cv, ca, a, b, c, d);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; claim_valid = 0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic        mr0, mr1, dr0, dr1;
  logic        p_v[2];
  logic [4:0]  p_a[2];
  logic [31:0] p_d[2];
  logic        acc[2];

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 5'd0;
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(1, 4));
    return 5'($urandom_range(1, 31));
  endfunction

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_addr = 0; req1_data = 0;
    claim_valid = 0; claim_addr = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_rf_we",    rf_we,    1'b0);
    check("reset_rf_addr",  rf_addr,  5'd0);
    check("reset_rf_wdata", rf_wdata, 32'd0);
    check("reset_busy",     busy,     32'd0);
    check("reset_ready0",   req0_ready, 1'b0);
    check("reset_ready1",   req1_ready, 1'b0);
    rst_n = 1'b1;

    // Single write from requester 0.
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, mr0, mr1, dr0, dr1);
    check("single_ready0", dr0, 1'b1);
    check("single_we",     rf_we,    1'b1);
    check("single_addr",   rf_addr,  5'd5);
    check("single_data",   rf_wdata, 32'hDEADBEEF);
    idle(0, 0);
    check("single_we_drop", rf_we, 1'b0);

    // Both ports continuously valid alternate.
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 32'h11, 1, 2, 32'h22, 0, 0, mr0, mr1, dr0, dr1);
      check("alt_ready0", dr0, (i % 2) == 0);
      check("alt_ready1", dr1, (i % 2) == 1);
      check("alt_addr",   rf_addr,  (i % 2 == 0) ? 5'd1 : 5'd2);
      check("alt_data",   rf_wdata, (i % 2 == 0) ? 32'h11 : 32'h22);
    end

    // x0 write alongside a real write; then priority still favours req0.
    step(1, 0, 32'h99, 1, 7, 32'h77, 0, 0, mr0, mr1, dr0, dr1);
    check("x0_ready0", dr0, 1'b1);
    check("x0_ready1", dr1, 1'b1);
    check("x0_addr",   rf_addr, 5'd7);
    step(1, 3, 32'h33, 1, 4, 32'h44, 0, 0, mr0, mr1, dr0, dr1);
    check("x0_then_ready0", dr0, 1'b1);
    check("x0_then_ready1", dr1, 1'b0);
    idle(0, 0);

    // Scoreboard: claim x9, write it three cycles later.
    idle(1, 9);
    check("claim9_set", busy[9], 1'b1);
    idle(0, 0);
    idle(0, 0);
    step(1, 9, 32'h909, 0, 0, 0, 0, 0, mr0, mr1, dr0, dr1);
    check("claim9_held", busy[9], 1'b1);
    idle(0, 0);
    check("claim9_clear", busy[9], 1'b0);
    idle(1, 9);
    step(0, 0, 0, 1, 9, 32'h919, 0, 0, mr0, mr1, dr0, dr1);
    idle(1, 9);
    check("claim9_wins", busy[9], 1'b1);
    idle(1, 0);
    check("claim0_busy", busy, 32'h0000_0200);

    // Reset between handshake and write.
    step(1, 3, 32'hCAFE, 0, 0, 0, 1, 4, mr0, mr1, dr0, dr1);
    check("pre_rst_we", rf_we, 1'b1);
    check("pre_rst_busy4", busy[4], 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_we_drop", rf_we, 1'b0);
    check("rst_busy",    busy,  32'd0);
    req0_valid = 0; req1_valid = 0; claim_valid = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 6, 32'h66, 1, 8, 32'h88, 0, 0, mr0, mr1, dr0, dr1);
    check("post_rst_ready0", dr0, 1'b1);
    check("post_rst_ready1", dr1, 1'b0);
    idle(0, 0);

    // Randomized traffic with held requests.
    p_v[0] = 0; p_v[1] = 0; acc[0] = 0; acc[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_v[p] || acc[p]) begin
          p_v[p] = ($urandom_range(0, 3) != 0);
          p_a[p] = rand_addr();
          p_d[p] = $urandom;
        end
      end
      step(p_v[0], p_a[0], p_d[0], p_v[1], p_a[1], p_d[1],
           ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
           mr0, mr1, dr0, dr1);
      acc[0] = p_v[0] && mr0;
      acc[1] = p_v[1] && mr1;
    end
    idle(0, 0);
    idle(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port (WE3/A3/WD3) between two writeback requesters, e.g. the ALU writeback path and a multi-cycle load/multiply unit. Arbitrates round-robin with a valid/ready handshake and drives the write port from a registered output stage. Maintains a 32-bit pending-write scoreboard so the issue logic can stall on registers that still await a write. Sits between the execute/memory units and the register file.

## Interface

- DATA_WIDTH, 32, width of write data
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has a write pending
- req0_ready  output  1  requester 0 write accepted this cycle
- req0_addr  input  5  destination register of requester 0
- req0_data  input  DATA_WIDTH  write data of requester 0
- req1_valid / req1_ready / req1_addr / req1_data  same as requester 0, for requester 1
- claim_valid  input  1  issue logic reserves a destination register this cycle
- claim_addr  input  5  register being reserved
- busy  output  32  bit n = 1: register n has an outstanding write
- rf_we  output  1  to register file WE3
- rf_addr  output  5  to register file A3
- rf_wdata  output  DATA_WIDTH  to register file WD3

## Operation

- A transfer on port N occurs on a rising edge where reqN_valid && reqN_ready.
- Requesters hold valid, addr and data stable until accepted. Valid must not depend on ready.
- Writes to x0: reqN_ready = reqN_valid, regardless of the other port. The write is accepted and discarded. It consumes no grant and does not move the priority pointer.
- Nonzero writes: at most one granted per cycle.
  - One valid: that port is granted.
  - Both valid: the port holding priority is granted.
- Priority pointer: 1-bit register, reset 0 (requester 0 first). After a grant to port N it points to the other port.
- Ready is combinational from the valids, the addresses and the pointer.
- Output stage, on each edge:
  - Nonzero grant: rf_we <= 1, rf_addr <= granted addr, rf_wdata <= granted data.
  - Otherwise: rf_we <= 0; rf_addr and rf_wdata hold their values.
- Scoreboard:
  - claim_valid with nonzero claim_addr sets busy[claim_addr].
  - On an edge with rf_we = 1, busy[rf_addr] is cleared.
  - Claim and clear of the same register on the same edge: claim wins, bit stays 1.
  - Claim of an already-busy register: bit stays 1.
  - busy[0] is constant 0.
- Writes to a non-busy register are performed normally. No error is flagged.

## Timing

- Reset values: rf_we 0, rf_addr 0, rf_wdata 0, busy all 0, pointer 0. req0_ready/req1_ready follow the combinational rule, so they are 0 when their valids are 0.
- Reset assertion takes effect immediately, mid-operation. rf_we drops at once and any captured, unperformed write is lost. Scoreboard bits clear. Requesters must re-present after reset.
- Latency:
  - Handshake at edge E: rf_we = 1 during cycle E..E+1.
  - The register file writes at edge E+1.
  - The new value is readable and the busy bit clears after edge E+1.
- Throughput: one nonzero write per cycle sustained. Both ports continuously valid alternate 0,1,0,1.
- No combinational path exists from any input to rf_we, rf_addr, rf_wdata or busy.

## Test plan

- Reset, then req0 x5 = 0xDEADBEEF alone: req0_ready = 1 in the request cycle. The next cycle shows rf_we = 1, rf_addr = 5, rf_wdata = 0xDEADBEEF. The following cycle shows rf_we = 0.
- Both ports valid with nonzero addresses (x1 = 0x11, x2 = 0x22) held for 4 cycles after reset:
  - Grants go 0,1,0,1.
  - rf_addr sequence 1,2,1,2 on consecutive cycles.
  - The losing port's ready = 0 in each cycle.
- req0 to x0 and req1 to x7 in the same cycle: both readies = 1. Only x7 is written. The pointer then favors req0.
- Claim x9, then a write to x9 accepted 3 cycles later:
  - busy[9] = 1 from the edge after the claim.
  - busy[9] clears one edge after rf_we = 1 with rf_addr = 9.
  - A claim of x9 in that same clearing cycle keeps busy[9] = 1.
- Claim of x0: busy stays 0.
- Assert rst_n low between handshake and write:
  - rf_we drops immediately, busy goes 0, the pointer returns to 0.
  - After release, the first simultaneous request goes to req0.
